// File: rtl/wb_trace_unit.sv
// Reset sequencer plus write-back trace capture: holds the core in reset, then
// records write-backs into a circular buffer and folds them into a MISR.
module wb_trace_unit #(
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 16,
  parameter int                RST_HOLD = 2,
  parameter logic [DATA_W-1:0] SIG_POLY = DATA_W'(32'h04C11DB7)
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       core_rst,
  input  logic                       wb_valid,
  input  logic [DATA_W-1:0]          wb_data,
  input  logic                       trace_en,
  input  logic                       stop_on_full,
  input  logic                       freeze,
  input  logic                       resume,
  input  logic                       rd_req,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_valid,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic [DATA_W-1:0]          signature,
  output logic [31:0]                wb_count,
  output logic                       frozen,
  output logic [1:0]                 state_dbg
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD - 1);
  localparam logic [CW-1:0] FULL      = CW'(DEPTH);

  typedef enum logic [1:0] {ST_HOLD, ST_RUN, ST_FROZEN} state_e;

  state_e              state_q, state_d;
  logic [HW-1:0]       hold_q, hold_d;
  logic                core_rst_q, core_rst_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic                ovf_q, ovf_d;
  logic [DATA_W-1:0]   sig_q, sig_d;
  logic [31:0]         wbc_q, wbc_d;
  logic                rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                mem_we;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    core_rst_d = core_rst_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    sig_d      = sig_q;
    wbc_d      = wbc_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    mem_we     = 1'b0;
    case (state_q)
      ST_HOLD: begin
        if (hold_q == HOLD_LAST) begin
          state_d    = ST_RUN;
          core_rst_d = 1'b0;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      ST_RUN: begin
        if (wb_valid) begin
          wbc_d = (wbc_q == 32'hFFFF_FFFF) ? wbc_q : wbc_q + 32'd1;
          sig_d = {sig_q[DATA_W-2:0], 1'b0} ^ (sig_q[DATA_W-1] ? SIG_POLY : '0) ^ wb_data;
          if (trace_en) begin
            if (count_q != FULL) begin
              mem_we   = 1'b1;
              wr_ptr_d = wr_ptr_q + AW'(1);
              count_d  = count_q + CW'(1);
              if (stop_on_full && (count_q == FULL - CW'(1))) state_d = ST_FROZEN;
            end else if (!stop_on_full) begin
              mem_we   = 1'b1;
              wr_ptr_d = wr_ptr_q + AW'(1);
              rd_ptr_d = rd_ptr_q + AW'(1);
              ovf_d    = 1'b1;
            end else begin
              // Already full in stop mode: keep the oldest data, just stop.
              state_d = ST_FROZEN;
            end
          end
        end
        if (freeze) state_d = ST_FROZEN;
      end
      ST_FROZEN: begin
        if (rd_req && (count_q != '0)) begin
          rd_valid_d = 1'b1;
          rd_data_d  = mem_q[rd_ptr_q];
          rd_ptr_d   = rd_ptr_q + AW'(1);
          count_d    = count_q - CW'(1);
        end
        if (resume && !freeze) state_d = ST_RUN;
      end
      default: state_d = ST_HOLD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_HOLD;
      hold_q     <= '0;
      core_rst_q <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      sig_q      <= '0;
      wbc_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      core_rst_q <= core_rst_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      sig_q      <= sig_d;
      wbc_q      <= wbc_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Trace storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (rst && mem_we) mem_q[wr_ptr_q] <= wb_data;
  end

  assign core_rst  = core_rst_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign signature = sig_q;
  assign wb_count  = wbc_q;
  assign frozen    = (state_q == ST_FROZEN);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_wb_trace_unit.sv
// Directed bench for wb_trace_unit (DEPTH=4, RST_HOLD=2) with a reference
// FIFO/MISR model; popped data is checked against an expected queue.
module tb_wb_trace_unit;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          core_rst;
  logic          wb_valid;
  logic [DW-1:0] wb_data;
  logic          trace_en;
  logic          stop_on_full;
  logic          freeze;
  logic          resume;
  logic          rd_req;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic [2:0]    count;
  logic          overflow;
  logic [DW-1:0] signature;
  logic [31:0]   wb_count;
  logic          frozen;
  logic [1:0]    state_dbg;

  wb_trace_unit #(.DATA_W(DW), .DEPTH(DEPTH), .RST_HOLD(2)) dut (
    .clk(clk), .rst(rst), .core_rst(core_rst),
    .wb_valid(wb_valid), .wb_data(wb_data), .trace_en(trace_en),
    .stop_on_full(stop_on_full), .freeze(freeze), .resume(resume),
    .rd_req(rd_req), .rd_data(rd_data), .rd_valid(rd_valid),
    .count(count), .overflow(overflow), .signature(signature),
    .wb_count(wb_count), .frozen(frozen), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] m_sig;
  logic [31:0]   m_wbc;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] misr(input logic [DW-1:0] s, input logic [DW-1:0] d);
    misr = {s[DW-2:0], 1'b0} ^ (s[DW-1] ? 32'h04C11DB7 : 32'h0) ^ d;
  endfunction

  // acc: the DUT is in RUN and must accept this write-back.
  task automatic do_wb(input logic [DW-1:0] d, input bit acc);
    wb_valid = 1'b1;
    wb_data  = d;
    tick();
    wb_valid = 1'b0;
    wb_data  = DW'($urandom_range(0, 255));
    if (acc) begin
      m_sig = misr(m_sig, d);
      m_wbc = m_wbc + 1;
      if (trace_en) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(d);
        else if (!stop_on_full) begin
          void'(exp_q.pop_front());
          exp_q.push_back(d);
        end
      end
    end
  endtask

  task automatic do_pop(input string tag);
    logic [DW-1:0] e;
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_valid"}, 64'(rd_valid), 64'd1);
      if (rd_valid) chk({tag, "_data"}, 64'(rd_data), 64'(e));
    end else begin
      chk({tag, "_novalid"}, 64'(rd_valid), 64'd0);
    end
  endtask

  task automatic pulse_freeze();
    freeze = 1'b1; tick(); freeze = 1'b0;
  endtask

  task automatic pulse_resume();
    resume = 1'b1; tick(); resume = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    exp_q.delete();
    m_sig = '0;
    m_wbc = '0;
    tick();
    chk("hold_core_rst_1", 64'(core_rst), 64'd1);
    tick();
    chk("hold_core_rst_2", 64'(core_rst), 64'd0);
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_sig"},   64'(signature), 64'(m_sig));
    chk({tag, "_wbc"},   64'(wb_count),  64'(m_wbc));
    chk({tag, "_count"}, 64'(count),     64'(exp_q.size()));
  endtask

  initial begin
    rst = 1'b0; wb_valid = 1'b0; wb_data = '0; trace_en = 1'b0;
    stop_on_full = 1'b0; freeze = 1'b0; resume = 1'b0; rd_req = 1'b0;
    m_sig = '0; m_wbc = '0;

    // Reset values and hold sequence
    tick(); tick(); tick();
    chk("rst_core_rst", 64'(core_rst), 64'd1);
    chk("rst_count",    64'(count),    64'd0);
    chk("rst_ovf",      64'(overflow), 64'd0);
    chk("rst_sig",      64'(signature), 64'd0);
    chk("rst_wbc",      64'(wb_count), 64'd0);
    chk("rst_rdv",      64'(rd_valid), 64'd0);
    chk("rst_rdd",      64'(rd_data),  64'd0);
    chk("rst_frozen",   64'(frozen),   64'd0);
    rst = 1'b1;
    tick();
    chk("rel_core_rst_1", 64'(core_rst), 64'd1);
    tick();
    chk("rel_core_rst_2", 64'(core_rst), 64'd0);

    // Signature only
    do_wb(32'h1, 1'b1);
    chk("sig_1", 64'(signature), 64'h1);
    do_wb(32'h2, 1'b1);
    chk("sig_2", 64'(signature), 64'h0);
    do_wb(32'h8000_0000, 1'b1);
    chk("sig_3", 64'(signature), 64'h8000_0000);
    do_wb(32'h0, 1'b1);
    chk("sig_4", 64'(signature), 64'h04C1_1DB7);
    chk("sig_wbc", 64'(wb_count), 64'd4);
    chk("sig_count", 64'(count), 64'd0);

    // Wrap mode
    trace_en = 1'b1;
    for (int i = 0; i < 6; i++) do_wb(32'h10 + 32'(i), 1'b1);
    chk("wrap_count", 64'(count), 64'd4);
    chk("wrap_ovf", 64'(overflow), 64'd1);
    chk_model("wrap");
    pulse_freeze();
    chk("wrap_frozen", 64'(frozen), 64'd1);
    chk("wrap_q0", 64'(exp_q[0]), 64'h12);
    for (int i = 0; i < 5; i++) do_pop("wrap_pop");
    chk("wrap_ovf_after", 64'(overflow), 64'd1);
    chk("wrap_count_after", 64'(count), 64'd0);

    // Stop-on-full (overflow must start clear)
    do_reset();
    trace_en = 1'b1;
    stop_on_full = 1'b1;
    for (int i = 0; i < 4; i++) do_wb(32'hA0 + 32'(i), 1'b1);
    chk("sof_frozen", 64'(frozen), 64'd1);
    do_wb(32'hA4, 1'b0);
    do_wb(32'hA5, 1'b0);
    chk("sof_count", 64'(count), 64'd4);
    chk("sof_ovf", 64'(overflow), 64'd0);
    chk("sof_wbc", 64'(wb_count), 64'd4);
    chk_model("sof");
    for (int i = 0; i < 4; i++) do_pop("sof_pop");

    // Freeze / resume
    pulse_resume();
    chk("fr_run", 64'(frozen), 64'd0);
    stop_on_full = 1'b0;
    do_wb(32'h1, 1'b1);
    do_wb(32'h2, 1'b1);
    freeze = 1'b1;
    do_wb(32'h3, 1'b1);
    freeze = 1'b0;
    chk("fr_count3", 64'(count), 64'd3);
    chk("fr_frozen", 64'(frozen), 64'd1);
    do_pop("fr_pop1");
    pulse_resume();
    do_wb(32'h4, 1'b1);
    pulse_freeze();
    for (int i = 0; i < 3; i++) do_pop("fr_pop");
    chk_model("fr");
    pulse_resume();
    do_wb(32'h55, 1'b1);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    chk("run_rdreq_rdv", 64'(rd_valid), 64'd0);
    chk("run_rdreq_count", 64'(count), 64'd1);

    // Reset in the middle of a readout
    do_wb(32'h66, 1'b1);
    do_wb(32'h77, 1'b1);
    pulse_freeze();
    chk("mid_count3", 64'(count), 64'd3);
    rd_req = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    rd_req = 1'b0;
    chk("mid_count", 64'(count), 64'd0);
    chk("mid_frozen", 64'(frozen), 64'd0);
    chk("mid_rdv", 64'(rd_valid), 64'd0);
    chk("mid_core_rst", 64'(core_rst), 64'd1);
    rst = 1'b1;
    wb_valid = 1'b1;
    wb_data  = 32'hDEAD;
    tick();
    chk("mid_hold_1", 64'(core_rst), 64'd1);
    tick();
    wb_valid = 1'b0;
    chk("mid_hold_2", 64'(core_rst), 64'd0);
    chk("mid_hold_wbc", 64'(wb_count), 64'd0);
    chk("mid_hold_sig", 64'(signature), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_trace_unit.md
Name: wb_trace_unit

Overview:
Parametrised reset sequencer and write-back trace capture unit that sits between the system clock/reset and the processor core. It generates the core's reset after a programmable hold period. It records the core's register write-back stream into a circular trace buffer and folds every write-back into a running MISR signature. It supports freeze/readout for in-system debug and self-checking simulation.

Parameters:
DATA_W, 32, width of write-back data, trace entries and signature
DEPTH, 16, trace buffer entries; must be a power of 2 and at least 2
RST_HOLD, 2, cycles core_rst stays high after rst is sampled high; must be at least 1
SIG_POLY, 32'h04C11DB7, MISR feedback polynomial, truncated to DATA_W

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  synchronous, active-low reset
core_rst  output  1  active-high reset to processor core
wb_valid  input  1  core write-back strobe
wb_data  input  DATA_W  core write-back value (reg_write_data)
trace_en  input  1  enable buffer capture (signature unaffected)
stop_on_full  input  1  1 = freeze when buffer fills; 0 = wrap, overwriting oldest
freeze  input  1  request transition RUN->FROZEN
resume  input  1  request transition FROZEN->RUN
rd_req  input  1  pop oldest trace entry (FROZEN only)
rd_data  output  DATA_W  popped entry
rd_valid  output  1  rd_data valid, single-cycle pulse
count  output  $clog2(DEPTH)+1  entries held, 0..DEPTH
overflow  output  1  sticky: an entry was overwritten
signature  output  DATA_W  running MISR value
wb_count  output  32  accepted write-backs, saturating at 32'hFFFFFFFF
frozen  output  1  state == FROZEN

Behaviour:
- Reset (rst==0 at posedge):
  - state=HOLD, hold counter=0, core_rst=1.
  - count=0, rd/wr pointers=0, overflow=0, signature=0, wb_count=0, rd_valid=0, rd_data=0, frozen=0.
  - Buffer RAM contents are not reset.
- States:
  - HOLD: hold counter increments each cycle rst==1. On the cycle the counter equals RST_HOLD-1: next state RUN and core_rst<=0. core_rst is therefore high for exactly RST_HOLD posedges after the first posedge sampling rst==1. All wb/rd inputs are ignored.
  - RUN: a write-back is accepted when wb_valid==1.
    - Each accepted write-back: wb_count++ (saturating); signature <= {sig[DATA_W-2:0],1'b0} ^ (sig[DATA_W-1] ? SIG_POLY : 0) ^ wb_data.
    - If trace_en also ==1: mem[wr_ptr]<=wb_data, wr_ptr++ mod DEPTH.
    - count<DEPTH: count++.
    - count==DEPTH, stop_on_full==0: rd_ptr++ (oldest dropped), count unchanged, overflow<=1.
    - stop_on_full==1 and the write makes count==DEPTH: next state FROZEN. overflow is never set in this mode.
    - freeze==1: next state FROZEN. A same-cycle write-back is still accepted.
    - rd_req is ignored.
  - FROZEN: frozen=1, wb_valid ignored (no capture, no signature or wb_count update). core_rst stays 0.
    - rd_req with count>0: next cycle rd_data=mem[rd_ptr], rd_valid=1; rd_ptr++, count--.
    - rd_req with count==0: rd_valid=0, no change.
    - resume==1: next state RUN; buffer, pointers and overflow retained. If rd_req and resume are both high, the pop is performed.
    - freeze and resume both high: stays FROZEN.
- Read latency is 1 cycle. Back-to-back rd_req pops one entry per cycle. rd_valid is low in every cycle without a successful pop.
- Pointer wrap is modulo DEPTH, with no bubbles.
- Reset mid-operation (any state): full reset as above, core_rst re-asserted the same edge, and the HOLD sequence restarts.

Test Plan:
- Reset sequence (RST_HOLD=2): hold rst=0 for 3 cycles, release -> core_rst high for exactly 2 posedges after release then 0; all outputs at reset values.
- Signature (DATA_W=32, trace_en=0): write-backs 0x1, 0x2 -> signature 0x1 then 0x0. Then 0x80000000, 0x0 -> 0x80000000 then 0x04C11DB7; wb_count=4, count=0.
- Wrap mode (DEPTH=4, stop_on_full=0): write 0x10..0x15 (6 values), freeze, pop 5 times -> rd_data 0x12, 0x13, 0x14, 0x15; 5th pop rd_valid=0; overflow=1, count=0.
- Stop-on-full (DEPTH=4, stop_on_full=1): write 0xA0..0xA5 -> frozen=1 after 0xA3, count=4, overflow=0, wb_count=4; pops return 0xA0..0xA3.
- Freeze/resume: write 0x1, 0x2, freeze with simultaneous write 0x3 -> count=3. Pop once (0x1), resume, write 0x4, freeze, pop 3 -> 0x2, 0x3, 0x4. rd_req during RUN -> no rd_valid.
- Reset mid-readout: in FROZEN with count=3, assert rst=0 one cycle -> count=0, frozen=0, rd_valid=0, core_rst=1, HOLD restarts.
